// File: rtl/stagemem_pkg.sv
// Shared definitions for the memory stage: funct3 access codes, FSM states and
// small address-alignment helpers used by the stage and its lane-steering block.
package stagemem_pkg;

    // Access size/sign codes carried in funct3
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    // sz is funct3[1:0]: 0 = byte, 1 = half, anything else = word
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

    // Clear the low address bits that cannot be honoured for this size
    function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return lo;
            2'b01:   return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/stagemem_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface stagemem_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        output bmask,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        input  bmask,
        output ack,
        output rdata
    );

endinterface

// File: rtl/stagemem_lsu_align.sv
// lsu_align: purely combinational byte-lane logic for the memory stage.
// Store side: replicate store data across lanes and build the byte mask.
// Load side: pick the addressed byte/half out of the read word and extend it.
module stagemem_lsu_align
    import stagemem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_lo_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_bmask_o,
    input  logic [2:0]  ld_f3_i,
    input  logic [1:0]  ld_lo_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store lane steering
    always_comb begin
        st_wdata_o = st_data_i;
        st_bmask_o = 4'b1111;
        case (st_size_i)
            2'b00: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_bmask_o = 4'b0001 << st_lo_i;
            end
            2'b01: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_bmask_o = st_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata_o = st_data_i;
                st_bmask_o = 4'b1111;
            end
        endcase
    end

    // Load extract and sign/zero extension
    always_comb begin
        byte_sel  = ld_word_i[7:0];
        half_sel  = ld_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_data_o = ld_word_i;
        case (ld_lo_i)
            2'd0:    byte_sel = ld_word_i[7:0];
            2'd1:    byte_sel = ld_word_i[15:8];
            2'd2:    byte_sel = ld_word_i[23:16];
            default: byte_sel = ld_word_i[31:24];
        endcase
        case (ld_f3_i)
            F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ld_data_o = {24'd0, byte_sel};
            F3_HU:   ld_data_o = {16'd0, half_sel};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/stagemem.sv
// Memory stage: issues loads/stores from the MEM pipeline slot onto the req/ack data bus,
// stalls the pipeline while an access is outstanding, and returns extended load data.
// FSM IDLE -> BUSY -> RESP -> IDLE; a BUSY phase that sees no ack within TIMEOUT_CYC
// cycles completes with a bus error.
// Build option: define MISALIGN_TRAP_EN to reject misaligned H/W accesses with an
// o_misaligned pulse; otherwise the offending low address bits are cleared.
module stagemem
    import stagemem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid_mem,
    input  logic        i_mem_rden,
    input  logic        i_mem_wren,
    input  logic [2:0]  i_funct3_mem,
    input  logic [31:0] i_alu_data_mem,
    input  logic [31:0] i_rs2_data_mem,
    stagemem_if.master  dmem,
    output logic [31:0] o_ld_data,
    output logic        o_done,
    output logic        o_stall,
    output logic        o_bus_err,
    output logic        o_misaligned
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  bmask_q, bmask_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        err_q, err_d;

    logic        mem_op;
    logic        misaligned;
    logic        accept;
    logic [1:0]  eff_lo;
    logic [31:0] st_wdata;
    logic [3:0]  st_bmask;
    logic [31:0] ld_ext;

    // Decode the presented instruction and decide whether it is issued this cycle
    always_comb begin
        mem_op = i_valid_mem & (i_mem_rden | i_mem_wren);
`ifdef MISALIGN_TRAP_EN
        misaligned   = is_misaligned(i_funct3_mem[1:0], i_alu_data_mem[1:0]);
        eff_lo       = i_alu_data_mem[1:0];
        o_misaligned = (state_q == IDLE) & mem_op & misaligned & ~i_reset;
`else
        misaligned   = 1'b0;
        eff_lo       = align_lo(i_funct3_mem[1:0], i_alu_data_mem[1:0]);
        o_misaligned = 1'b0;
`endif
        accept  = (state_q == IDLE) & mem_op & ~misaligned & ~i_reset;
        o_stall = accept | (state_q == BUSY);
    end

    stagemem_lsu_align u_lsu_align (
        .st_size_i  (i_funct3_mem[1:0]),
        .st_lo_i    (eff_lo),
        .st_data_i  (i_rs2_data_mem),
        .st_wdata_o (st_wdata),
        .st_bmask_o (st_bmask),
        .ld_f3_i    (f3_q),
        .ld_lo_i    (lo_q),
        .ld_word_i  (dmem.rdata),
        .ld_data_o  (ld_ext)
    );

    // Next-state logic for the access FSM, timeout counter and bus/output registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bmask_d   = bmask_q;
        f3_d      = f3_q;
        lo_d      = lo_q;
        ld_data_d = ld_data_q;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = 16'd0;
                    req_d   = 1'b1;
                    we_d    = i_mem_wren;
                    addr_d  = {i_alu_data_mem[31:2], 2'b00};
                    wdata_d = st_wdata;
                    bmask_d = st_bmask;
                    f3_d    = i_funct3_mem;
                    lo_d    = eff_lo;
                end
            end
            BUSY: begin
                if (dmem.ack) begin
                    state_d   = RESP;
                    req_d     = 1'b0;
                    ld_data_d = we_q ? 32'd0 : ld_ext;
                end else if (cnt_q == TimeoutLast) begin
                    state_d   = RESP;
                    req_d     = 1'b0;
                    ld_data_d = 32'd0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            bmask_q   <= 4'd0;
            f3_q      <= 3'd0;
            lo_q      <= 2'd0;
            ld_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bmask_q   <= bmask_d;
            f3_q      <= f3_d;
            lo_q      <= lo_d;
            ld_data_q <= ld_data_d;
            err_q     <= err_d;
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem.bmask = bmask_q;
    assign o_ld_data  = ld_data_q;
    assign o_done     = (state_q == RESP);
    assign o_bus_err  = err_q;

endmodule

// File: tb/tb_stagemem.sv
// Self-checking bench for stagemem: directed scenarios plus random loads/stores,
// all checked against a byte-level model of the memory stage.
module tb_stagemem;
    import stagemem_pkg::*;

    localparam int unsigned TIMEOUT = 8;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, rden, wren;
    logic [2:0]  f3;
    logic [31:0] alu, rs2;
    logic [31:0] ld_data;
    logic        done, stall, bus_err, mis_o;
    int          checks = 0;
    int          failures = 0;

    stagemem_if dmem_bus ();

    stagemem #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_valid_mem    (valid),
        .i_mem_rden     (rden),
        .i_mem_wren     (wren),
        .i_funct3_mem   (f3),
        .i_alu_data_mem (alu),
        .i_rs2_data_mem (rs2),
        .dmem           (dmem_bus),
        .o_ld_data      (ld_data),
        .o_done         (done),
        .o_stall        (stall),
        .o_bus_err      (bus_err),
        .o_misaligned   (mis_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] code);
        logic [1:0] s;
        s = code[1:0];
        if (s == 2'd0) return 1;
        if (s == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_mis(input logic [2:0] code, input logic [31:0] a);
        return TRAP && ((a % size_of(code)) != 0);
    endfunction

    function automatic int model_lo(input logic [2:0] code, input logic [31:0] a);
        int sz;
        sz = size_of(code);
        return (int'(a % 4) / sz) * sz;
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] code, input logic [31:0] a);
        int m;
        m = ((1 << size_of(code)) - 1) << model_lo(code, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] code, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = size_of(code);
        w = 32'd0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] code, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [31:0] v, m;
        int sz;
        sz = size_of(code);
        v  = word >> (8 * model_lo(code, a));
        if (sz == 4) return v;
        m = (32'd1 << (8 * sz)) - 32'd1;
        v = v & m;
        if (!code[2] && v[8*sz-1]) v = v | ~m;
        return v;
    endfunction

    // ---------------- transaction driver with inline checks ----------------
    task automatic do_access(input string name, input bit is_store, input logic [2:0] code,
                             input logic [31:0] a, input logic [31:0] d, input int ack_delay,
                             input logic [31:0] word);
        bit          exp_mis, timed_out;
        int          busy_len;
        logic [31:0] exp_ld;
        exp_mis   = model_mis(code, a);
        timed_out = (ack_delay >= int'(TIMEOUT));
        busy_len  = timed_out ? int'(TIMEOUT) : ack_delay + 1;
        exp_ld    = (timed_out || is_store) ? 32'd0 : model_load(code, a, word);

        @(posedge clk); #1;
        valid = 1'b1; rden = !is_store; wren = is_store; f3 = code; alu = a; rs2 = d;
        dmem_bus.ack = 1'b0;
        #1;
        checks++;
        if (stall !== !exp_mis) begin
            failures++;
            $display("FAIL %s accept_stall: got %b want %b", name, stall, !exp_mis);
        end
        checks++;
        if (mis_o !== exp_mis) begin
            failures++;
            $display("FAIL %s misaligned: got %b want %b", name, mis_o, exp_mis);
        end
        if (exp_mis) begin
            @(posedge clk); #1;
            valid = 1'b0; rden = 1'b0; wren = 1'b0;
            #1;
            checks++;
            if (dmem_bus.req !== 1'b0 || done !== 1'b0 || mis_o !== 1'b0) begin
                failures++;
                $display("FAIL %s trap_no_req: got req=%b done=%b mis=%b want 0 0 0",
                         name, dmem_bus.req, done, mis_o);
            end
            return;
        end

        for (int k = 1; k <= busy_len; k++) begin
            @(posedge clk); #1;
            dmem_bus.ack   = (!timed_out && k == busy_len);
            dmem_bus.rdata = dmem_bus.ack ? word : $urandom;
            #1;
            checks++;
            if (dmem_bus.req !== 1'b1 || dmem_bus.we !== is_store || stall !== 1'b1 ||
                done !== 1'b0) begin
                failures++;
                $display("FAIL %s busy%0d_ctrl: got req=%b we=%b stall=%b done=%b want 1 %b 1 0",
                         name, k, dmem_bus.req, dmem_bus.we, stall, done, is_store);
            end
            checks++;
            if (dmem_bus.addr !== {a[31:2], 2'b00} || dmem_bus.bmask !== model_mask(code, a)) begin
                failures++;
                $display("FAIL %s busy%0d_addr: got %h/%b want %h/%b", name, k, dmem_bus.addr,
                         dmem_bus.bmask, {a[31:2], 2'b00}, model_mask(code, a));
            end
            if (is_store) begin
                checks++;
                if (dmem_bus.wdata !== model_wdata(code, d)) begin
                    failures++;
                    $display("FAIL %s busy%0d_wdata: got %h want %h", name, k, dmem_bus.wdata,
                             model_wdata(code, d));
                end
            end
        end

        @(posedge clk); #1;
        dmem_bus.ack = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || stall !== 1'b0 || dmem_bus.req !== 1'b0 || bus_err !== timed_out) begin
            failures++;
            $display("FAIL %s resp_ctrl: got done=%b stall=%b req=%b err=%b want 1 0 0 %b",
                     name, done, stall, dmem_bus.req, bus_err, timed_out);
        end
        checks++;
        if (ld_data !== exp_ld) begin
            failures++;
            $display("FAIL %s ld_data: got %h want %h", name, ld_data, exp_ld);
        end

        @(posedge clk); #1;
        valid = 1'b0; rden = 1'b0; wren = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || bus_err !== 1'b0 || dmem_bus.req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after: got done=%b err=%b req=%b stall=%b want 0 0 0 0",
                     name, done, bus_err, dmem_bus.req, stall);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; rden = 1'b0; wren = 1'b0; f3 = 3'd0; alu = 32'd0; rs2 = 32'd0;
        dmem_bus.ack = 1'b0; dmem_bus.rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dmem_bus.req !== 1'b0 || dmem_bus.we !== 1'b0 || dmem_bus.bmask !== 4'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got req=%b we=%b bmask=%b want 0 0 0000",
                     dmem_bus.req, dmem_bus.we, dmem_bus.bmask);
        end
        checks++;
        if (dmem_bus.addr !== 32'd0 || dmem_bus.wdata !== 32'd0 || ld_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h ld=%h want 0", dmem_bus.addr,
                     dmem_bus.wdata, ld_data);
        end
        checks++;
        if (done !== 1'b0 || bus_err !== 1'b0 || mis_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses: got done=%b err=%b mis=%b want 0", done, bus_err, mis_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_access("sw_104", 1'b1, F3_W, 32'h104, 32'hDEADBEEF, 0, 32'h0);
        do_access("lb_103", 1'b0, F3_B, 32'h103, 32'h0, 0, 32'h80112233);
        do_access("lbu_103", 1'b0, F3_BU, 32'h103, 32'h0, 0, 32'h80112233);
        do_access("sh_0a2", 1'b1, F3_H, 32'h0A2, 32'h0000ABCD, 0, 32'h0);
        do_access("lh_0a2", 1'b0, F3_H, 32'h0A2, 32'h0, 0, 32'h7FFF0000);
        do_access("lhu_0a0", 1'b0, F3_HU, 32'h0A0, 32'h0, 1, 32'h1234F00D);
        do_access("sb_0a1", 1'b1, F3_B, 32'h0A1, 32'h000000C3, 2, 32'h0);
    endtask

    task automatic test_timeout();
        do_access("lw_ack5", 1'b0, F3_W, 32'h200, 32'h0, 5, 32'hCAFEF00D);
        do_access("lw_ack_last", 1'b0, F3_W, 32'h204, 32'h0, int'(TIMEOUT) - 1, 32'h01020304);
        do_access("lw_noack", 1'b0, F3_W, 32'h208, 32'h0, 1000, 32'h0);
        do_access("sw_noack", 1'b1, F3_W, 32'h20C, 32'h55AA55AA, 1000, 32'h0);
    endtask

    task automatic test_misaligned();
        do_access("lw_102", 1'b0, F3_W, 32'h102, 32'h0, 0, 32'h89ABCDEF);
        do_access("lh_0a3", 1'b0, F3_H, 32'h0A3, 32'h0, 0, 32'h8001_7002);
        do_access("sw_301", 1'b1, F3_W, 32'h301, 32'h11223344, 0, 32'h0);
    endtask

    task automatic test_nonmem();
        @(posedge clk); #1;
        valid = 1'b1; rden = 1'b0; wren = 1'b0; f3 = F3_W; alu = 32'h400;
        #1;
        checks++;
        if (stall !== 1'b0 || mis_o !== 1'b0) begin
            failures++;
            $display("FAIL nonmem_stall: got stall=%b mis=%b want 0 0", stall, mis_o);
        end
        @(posedge clk); #1;
        valid = 1'b0; rden = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || dmem_bus.req !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL nonmem_req: got stall=%b req=%b done=%b want 0 0 0",
                     stall, dmem_bus.req, done);
        end
        @(posedge clk); #1;
        rden = 1'b0;
        #1;
        checks++;
        if (dmem_bus.req !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL invalid_req: got req=%b done=%b want 0 0", dmem_bus.req, done);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        valid = 1'b1; rden = 1'b1; wren = 1'b0; f3 = F3_W; alu = 32'h500;
        @(posedge clk); #1;
        valid = 1'b0; rden = 1'b0;
        #1;
        checks++;
        if (dmem_bus.req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy: got req=%b want 1", dmem_bus.req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (dmem_bus.req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_drop: got req=%b stall=%b done=%b want 0 0 0",
                     dmem_bus.req, stall, done);
        end
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || ld_data !== 32'd0 || dmem_bus.req !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_late_ack%0d: got done=%b ld=%h req=%b want 0 0 0",
                         k, done, ld_data, dmem_bus.req);
            end
        end
        dmem_bus.ack = 1'b0;
        do_access("lw_after_rst", 1'b0, F3_W, 32'h504, 32'h0, 0, 32'hA5A5_0F0F);
    endtask

    task automatic test_random();
        logic [2:0] ld_codes [5];
        logic [2:0] code;
        bit         st;
        int         dly;
        ld_codes[0] = F3_B; ld_codes[1] = F3_H; ld_codes[2] = F3_W;
        ld_codes[3] = F3_BU; ld_codes[4] = F3_HU;
        for (int n = 0; n < 60; n++) begin
            st   = bit'($urandom_range(0, 1));
            code = st ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
            dly  = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            do_access($sformatf("rnd%0d", n), st, code, $urandom, $urandom, dly, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_misaligned();
        test_nonmem();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
